uart_alu_interface: RTL
=======================

# uart_alu_interface

Sequencer between the UART receiver, the ALU and the UART transmitter. Collects three bytes from the receiver (operand A, operand B, opcode) and drives them as stable registered operands to the combinational ALU. It then captures the ALU result and hands it to the transmitter with a single start pulse. It owns the protocol order and is the only block that writes ALU inputs or starts a transmission.

## Interface
- NB_DATA, 8, width of operands, result and UART data bytes
- NB_OP, 6, opcode width; taken from rx_data[NB_OP-1:0]
- TIMEOUT_CYCLES, 1000000, inter-byte timeout in clk cycles (used only with UART_IF_TIMEOUT_EN; minimum 2)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- rx_done_tick  in  1  one-cycle pulse, rx_data valid
- rx_data  in  NB_DATA  received byte
- alu_result  in  NB_DATA  combinational ALU output
- tx_done_tick  in  1  one-cycle pulse, transmitter finished byte
- alu_a  out  NB_DATA  registered operand A
- alu_b  out  NB_DATA  registered operand B
- alu_op  out  NB_OP  registered opcode
- tx_start  out  1  one-cycle pulse, start transmission of tx_data
- tx_data  out  NB_DATA  registered result byte
- busy  out  1  high in CALC, SEND, WAIT_TX
- overrun  out  1  sticky: byte received while busy
- timeout  out  1  one-cycle pulse on inter-byte timeout (tied 0 without macro)

## Operation
- States: WAIT_A, WAIT_B, WAIT_OP, CALC, SEND, WAIT_TX. Reset state WAIT_A.
- WAIT_A: on rx_done_tick, alu_a <= rx_data, overrun <= 0, go WAIT_B.
- WAIT_B: on rx_done_tick, alu_b <= rx_data, go WAIT_OP.
- WAIT_OP: on rx_done_tick, alu_op <= rx_data[NB_OP-1:0], go CALC.
- CALC: one cycle; tx_data <= alu_result, go SEND.
- SEND: tx_start = 1 for this cycle only (Moore), go WAIT_TX.
- WAIT_TX: on tx_done_tick go WAIT_A; otherwise hold.
- rx_done_tick in CALC/SEND/WAIT_TX: byte dropped, overrun <= 1. It stays 1 until the next A is latched or reset.
- tx_done_tick outside WAIT_TX: ignored.
- alu_a/alu_b/alu_op/tx_data hold their value until overwritten; never cleared except by reset.
- Encoding/default: any illegal state returns to WAIT_A next cycle, no register writes.

## Timing
- Reset (reset=0): state WAIT_A; alu_a, alu_b, alu_op, tx_data = 0; tx_start, busy, overrun, timeout = 0. Takes effect immediately (async), release synchronous to clk.
- Reset mid-operation: sequence aborted, partial operands discarded, no tx_start issued.
- Latency: rx_done_tick for opcode sampled at edge N. alu_op valid and state CALC from cycle N+1. tx_data valid and tx_start high in cycle N+2. WAIT_TX from N+3.
- ALU must settle within one cycle (alu_op registered at N+1, result sampled at end of N+1).
- busy rises in the cycle state enters CALC; falls the cycle after tx_done_tick is sampled.
- Back-to-back: an rx_done_tick in the same cycle WAIT_TX exits is dropped (state still WAIT_TX when sampled) and sets overrun.

## Configuration
- UART_IF_TIMEOUT_EN defined: a counter of width $clog2(TIMEOUT_CYCLES) is cleared on entry to WAIT_B/WAIT_OP and increments each cycle there.
  - At TIMEOUT_CYCLES-1 with no rx_done_tick, go WAIT_A and pulse timeout for one cycle; alu_a/alu_b keep stale values.
  - rx_done_tick in the same cycle as terminal count wins: byte latched, no timeout.
- Undefined: no counter, timeout tied 0, WAIT_B/WAIT_OP wait indefinitely.

## Test plan
- Bytes 0x05, 0x03, 0x20 with ALU model A+B -> alu_a=0x05, alu_b=0x03, alu_op=0x20; tx_data=0x08, single tx_start pulse 2 cycles after opcode tick.
- Opcode byte 0xE2 -> alu_op=0x22 (upper bits discarded).
- Extra rx_done_tick (0x77) during WAIT_TX -> overrun=1, alu_a unchanged; after tx_done_tick and next A byte, overrun=0.
- Assert reset after the B byte -> all outputs 0, state WAIT_A, no tx_start; next three bytes processed normally.
- tx_done_tick pulsed in WAIT_A and WAIT_B -> ignored, no state change.
- UART_IF_TIMEOUT_EN, TIMEOUT_CYCLES=100: send A, then nothing -> timeout pulse 100 cycles after WAIT_B entry, back to WAIT_A. Byte on terminal-count cycle -> latched, no timeout.

Source files
------------

// File: rtl/uart_alu_interface.sv
// Purpose: sequences UART bytes (A, B, opcode) into registered ALU operands and hands the ALU result to the UART transmitter.
// Latency: opcode tick sampled at edge N -> CALC in N+1, tx_data valid and tx_start pulse in N+2, WAIT_TX from N+3.
// Backpressure: none upstream; bytes arriving while busy are dropped and flagged by the sticky overrun output.
//
// Ports:
//   clk, reset             clock (rising edge) and asynchronous active-low reset
//   rx_done_tick, rx_data  received-byte strobe and byte from the UART receiver
//   alu_result             combinational ALU output, sampled in CALC
//   tx_done_tick           transmitter finished strobe, honoured only in WAIT_TX
//   alu_a, alu_b, alu_op   registered ALU operands / opcode
//   tx_start, tx_data      one-cycle transmit start and registered result byte
//   busy, overrun, timeout status: busy in CALC/SEND/WAIT_TX, sticky overrun, timeout pulse
//
// Optional feature: define UART_IF_TIMEOUT_EN to enable the inter-byte timeout in
// WAIT_B / WAIT_OP. Without it, timeout is tied low and those states wait forever.

module uart_alu_interface #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_done_tick,
    input  logic [NB_DATA-1:0] rx_data,
    input  logic [NB_DATA-1:0] alu_result,
    input  logic               tx_done_tick,
    output logic [NB_DATA-1:0] alu_a,
    output logic [NB_DATA-1:0] alu_b,
    output logic [NB_OP-1:0]   alu_op,
    output logic               tx_start,
    output logic [NB_DATA-1:0] tx_data,
    output logic               busy,
    output logic               overrun,
    output logic               timeout
);

    // The terminal count must be reachable at least one cycle after entry.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_CALC    = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } state_t;

    state_t state;
    state_t state_next;

    // One-hot-ish write strobes decoded by the next-state logic.
    logic lat_a;
    logic lat_b;
    logic lat_op;
    logic lat_res;
    logic set_ovr;
    logic tmo_fire;

`ifdef UART_IF_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] tmo_cnt;
    logic             cnt_term;
    logic             cnt_enter;

    assign cnt_term  = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    // Clear on any transition into a byte-waiting state so each byte gets a full window.
    assign cnt_enter = ((state_next == ST_WAIT_B) || (state_next == ST_WAIT_OP)) &&
                       (state_next != state);
`endif

    // ------------------------------------------------------------------
    // Next-state and strobe decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        lat_a      = 1'b0;
        lat_b      = 1'b0;
        lat_op     = 1'b0;
        lat_res    = 1'b0;
        set_ovr    = 1'b0;
        tmo_fire   = 1'b0;

        case (state)
            ST_WAIT_A: begin
                if (rx_done_tick) begin
                    lat_a      = 1'b1;
                    state_next = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                // A byte on the terminal-count cycle takes priority over the timeout.
                if (rx_done_tick) begin
                    lat_b      = 1'b1;
                    state_next = ST_WAIT_OP;
                end
`ifdef UART_IF_TIMEOUT_EN
                else if (cnt_term) begin
                    tmo_fire   = 1'b1;
                    state_next = ST_WAIT_A;
                end
`endif
            end
            ST_WAIT_OP: begin
                if (rx_done_tick) begin
                    lat_op     = 1'b1;
                    state_next = ST_CALC;
                end
`ifdef UART_IF_TIMEOUT_EN
                else if (cnt_term) begin
                    tmo_fire   = 1'b1;
                    state_next = ST_WAIT_A;
                end
`endif
            end
            ST_CALC: begin
                // alu_op was registered last cycle, so the ALU has had a full cycle to settle.
                lat_res    = 1'b1;
                set_ovr    = rx_done_tick;
                state_next = ST_SEND;
            end
            ST_SEND: begin
                set_ovr    = rx_done_tick;
                state_next = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                // A byte in the exit cycle is still seen in WAIT_TX and is dropped.
                set_ovr = rx_done_tick;
                if (tx_done_tick) begin
                    state_next = ST_WAIT_A;
                end
            end
            default: begin
                state_next = ST_WAIT_A;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_WAIT_A;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers: hold until overwritten, cleared only by reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
            tx_data <= '0;
        end else begin
            if (lat_a) begin
                alu_a <= rx_data;
            end
            if (lat_b) begin
                alu_b <= rx_data;
            end
            if (lat_op) begin
                alu_op <= rx_data[NB_OP-1:0];
            end
            if (lat_res) begin
                tx_data <= alu_result;
            end
        end
    end

    // Sticky overrun: set by a dropped byte, cleared when a fresh operand A is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (lat_a) begin
            overrun <= 1'b0;
        end else if (set_ovr) begin
            overrun <= 1'b1;
        end
    end

`ifdef UART_IF_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= tmo_fire;
            if (cnt_enter) begin
                tmo_cnt <= '0;
            end else if ((state == ST_WAIT_B) || (state == ST_WAIT_OP)) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign timeout = 1'b0;

    logic unused_tmo;
    assign unused_tmo = tmo_fire;
`endif

    // ------------------------------------------------------------------
    // Moore outputs
    // ------------------------------------------------------------------
    assign tx_start = (state == ST_SEND);
    assign busy     = (state == ST_CALC) || (state == ST_SEND) || (state == ST_WAIT_TX);

endmodule
